// File: rtl/axi_pkg.sv
// Shared definitions for the SRAM-to-AXI3 bridge: FSM state codes, AXI
// encodings, default transaction IDs and SRAM size codes.
package axi_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AW_W = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int ID_INST = 0;
    localparam int ID_DATA = 1;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

endpackage

// File: rtl/sram_axi_arbiter_if.sv
// Single-ID AXI3 master bus (AR/R/AW/W/B) as seen by the SRAM bridge;
// master = bridge side, slave = crossbar side.
interface sram_axi_arbiter_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_strb_gen.sv
// Byte-lane strobe from SRAM size code and low address bits; purely combinational
// so the uncached store path can reuse it.
module axi_strb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    always_comb begin
        case (size)
            SIZE_B:  strb = 4'b0001 << addr_lo;
            SIZE_H:  strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Bridges the inst (read-only) and data SRAM-like ports onto one AXI3 master,
// one transaction at a time. Define ARB_ROUND_ROBIN_EN for round-robin grant.
//
// state   | meaning
// IDLE    | waiting for a request; grant and addr_ok happen here
// AR      | read address presented, waiting for arready
// R       | waiting for rvalid; data_ok pulses with it
// AW_W    | write address and data presented, each drops after its handshake
// B       | waiting for bvalid; data_data_ok pulses with it
module sram_axi_arbiter
    import axi_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int INST_ID = ID_INST,
    parameter int DATA_ID = ID_DATA
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    sram_axi_arbiter_if.master axi
);

    logic [2:0]  state_q, state_d;
    logic        owner_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic        aw_done_q, w_done_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic        idle, grant_data, grant_inst, grant_any;
    logic        r_fire, b_fire, aw_hs, w_hs, aw_fin, w_fin;
    logic [ID_W-1:0] owner_id;
    logic [3:0]  strb;

    // addr_ok is masked during reset so a held req cannot be acknowledged
    // while the bridge is being cleared.
    assign idle = (state_q == ST_IDLE) && !rst;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_data_q;
    logic contested;

    assign contested  = inst_req && data_req;
    assign grant_data = data_req && (!inst_req || rr_data_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_data_q <= 1'b1;
        else if (idle && contested)
            rr_data_q <= !grant_data;
    end
`else
    assign grant_data = data_req;
`endif

    assign grant_inst   = inst_req && !grant_data;
    assign inst_addr_ok = idle && grant_inst;
    assign data_addr_ok = idle && grant_data;
    assign grant_any    = inst_addr_ok || data_addr_ok;

    assign r_fire = (state_q == ST_R) && axi.rvalid;
    assign b_fire = (state_q == ST_B) && axi.bvalid;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    assign inst_data_ok = r_fire && !owner_q;
    assign data_data_ok = (r_fire && owner_q) || b_fire;
    assign inst_rdata   = inst_data_ok ? axi.rdata : inst_rdata_q;
    assign data_rdata   = (r_fire && owner_q) ? axi.rdata : data_rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = (grant_data && data_wr) ? ST_AW_W : ST_AR;
            ST_AR:   if (axi.arready) state_d = ST_R;
            ST_R:    if (axi.rvalid) state_d = ST_IDLE;
            ST_AW_W: if (aw_fin && w_fin) state_d = ST_B;
            ST_B:    if (axi.bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                owner_q   <= grant_data;
                wr_q      <= grant_data && data_wr;
                addr_q    <= grant_data ? data_addr : inst_addr;
                size_q    <= grant_data ? data_size : inst_size;
                wdata_q   <= grant_data ? data_wdata : 32'd0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (inst_data_ok)
                inst_rdata_q <= axi.rdata;
            if (r_fire && owner_q)
                data_rdata_q <= axi.rdata;
        end
    end

    axi_strb_gen u_strb_gen (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .strb    (strb)
    );

    assign owner_id = owner_q ? ID_W'(DATA_ID) : ID_W'(INST_ID);

    assign axi.arid    = owner_id;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state_q == ST_AR);
    assign axi.rready  = (state_q == ST_R);

    assign axi.awid    = owner_id;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = (state_q == ST_AW_W) && !aw_done_q;

    // Store data goes out unshifted; the core already replicates it per lane.
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign axi.bready  = (state_q == ST_B);

    // Response IDs/status are irrelevant with a single outstanding transaction.
    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, wr_q};

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Randomized bench for sram_axi_arbiter against a transaction-level model of
// grant order, strobes and returned data.
module tb_sram_axi_arbiter;

    localparam int ID_W = 4;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic [1:0]  data_size;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    sram_axi_arbiter_if #(.ID_W(ID_W)) axi ();

    sram_axi_arbiter #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: pending requests per port, preferred port, last returned data
    bit          pend_i, pend_d, d_wr_m, rr_m;
    logic [31:0] i_addr_m, d_addr_m, d_wdata_m, held_i, held_d;
    logic [1:0]  i_size_m, d_size_m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
        int nb, off;
        nb  = (size >= 2'd2) ? 4 : (1 << size);
        off = int'(addr % 32'd4) & ~(nb - 1);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    task automatic set_inst(input logic [31:0] a, input logic [1:0] s);
        pend_i = 1'b1; i_addr_m = a; i_size_m = s;
    endtask

    task automatic set_data(input bit wr, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        pend_d = 1'b1; d_wr_m = wr; d_addr_m = a; d_size_m = s; d_wdata_m = wd;
    endtask

    task automatic add_random_reqs();
        if (!pend_i && $urandom_range(0, 1) == 1)
            set_inst($urandom, 2'($urandom_range(0, 2)));
        if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i))
            set_data(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
    endtask

    // Entered and left at a negedge with the bridge idle.
    task automatic run_round(input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [31:0] rd_val, input bit abort_r);
        bit          win_d, t_wr, aw_hs, w_hs;
        logic [31:0] t_addr, t_wdata;
        logic [1:0]  t_size;
        inst_req   = pend_i;   inst_addr = i_addr_m; inst_size = i_size_m;
        data_req   = pend_d;   data_wr   = d_wr_m;   data_addr = d_addr_m;
        data_size  = d_size_m; data_wdata = d_wdata_m;
        if (pend_i && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = rr_m;
            rr_m  = !win_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = pend_d;
        end
        #1;
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(pend_i && !win_d));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(win_d));
        t_wr    = win_d && d_wr_m;
        t_addr  = win_d ? d_addr_m : i_addr_m;
        t_size  = win_d ? d_size_m : i_size_m;
        t_wdata = d_wdata_m;
        if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
        step();
        if (win_d) data_req = 1'b0; else inst_req = 1'b0;

        if (!t_wr) begin
            for (int c = 0; c <= ar_dly; c++) begin
                axi.arready = (c == ar_dly);
                #1;
                chk("arvalid", 32'(axi.arvalid), 32'd1);
                chk("araddr", axi.araddr, t_addr);
                chk("arid", 32'(axi.arid), 32'(win_d));
                chk("arsize", 32'(axi.arsize), 32'(t_size));
                chk("arlen_burst", 32'({axi.arlen, axi.arburst}), 32'd1);
                chk("addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
                step();
            end
            axi.arready = 1'b0;
            for (int c = 0; c <= r_dly; c++) begin
                if (abort_r && c == r_dly) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_valids", 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 32'd0);
                    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
                    held_i = '0; held_d = '0; rr_m = 1'b1;
                    step();
                    rst = 1'b0;
                    axi.rvalid = 1'b1;
                    axi.rdata  = rd_val;
                    #1;
                    chk("late_rvalid_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
                    chk("late_rvalid_rdata", inst_rdata, held_i);
                    step();
                    axi.rvalid = 1'b0;
                    return;
                end
                axi.rvalid = (c == r_dly);
                axi.rdata  = (c == r_dly) ? rd_val : $urandom;
                #1;
                chk("rready", 32'(axi.rready), 32'd1);
                chk("inst_data_ok", 32'(inst_data_ok), 32'(!win_d && c == r_dly));
                chk("data_data_ok", 32'(data_data_ok), 32'(win_d && c == r_dly));
                if (c == r_dly) begin
                    if (win_d) held_d = rd_val; else held_i = rd_val;
                end
                chk("inst_rdata", inst_rdata, held_i);
                chk("data_rdata", data_rdata, held_d);
                step();
            end
            axi.rvalid = 1'b0;
        end else begin
            aw_hs = 1'b0;
            w_hs  = 1'b0;
            for (int c = 0; c < 16 && !(aw_hs && w_hs); c++) begin
                axi.awready = !aw_hs && c >= aw_dly;
                axi.wready  = !w_hs && c >= w_dly;
                #1;
                chk("awvalid", 32'(axi.awvalid), 32'(!aw_hs));
                if (!aw_hs) begin
                    chk("awaddr", axi.awaddr, t_addr);
                    chk("awsize", 32'(axi.awsize), 32'(t_size));
                    chk("awid", 32'(axi.awid), 32'd1);
                    chk("awlen_burst", 32'({axi.awlen, axi.awburst}), 32'd1);
                end
                chk("wvalid", 32'(axi.wvalid), 32'(!w_hs));
                if (!w_hs) begin
                    chk("wdata", axi.wdata, t_wdata);
                    chk("wstrb", 32'(axi.wstrb), 32'(model_strb(t_size, t_addr)));
                    chk("wlast", 32'(axi.wlast), 32'd1);
                end
                chk("addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
                chk("data_ok_early", 32'(data_data_ok), 32'd0);
                if (axi.awready) aw_hs = 1'b1;
                if (axi.wready)  w_hs  = 1'b1;
                step();
            end
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            for (int c = 0; c <= b_dly; c++) begin
                axi.bvalid = (c == b_dly);
                #1;
                chk("bready", 32'(axi.bready), 32'd1);
                chk("wr_data_data_ok", 32'(data_data_ok), 32'(c == b_dly));
                chk("wr_inst_data_ok", 32'(inst_data_ok), 32'd0);
                chk("wr_data_rdata", data_rdata, held_d);
                step();
            end
            axi.bvalid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (pend_i || pend_d); k++)
            run_round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        inst_req = 1'b1; inst_addr = '0; inst_size = '0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = '0; data_size = '0; data_wdata = '0;
        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b1;
        axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
        pend_i = 0; pend_d = 0; d_wr_m = 0; rr_m = 1;
        i_addr_m = '0; d_addr_m = '0; d_wdata_m = '0; i_size_m = '0; d_size_m = '0;
        held_i = '0; held_d = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("rst_valids", 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // plain fetch, minimum latency
        set_inst(32'hBFC0_0000, 2'd2);
        run_round(0, 0, 0, 0, 0, 32'h3C1D_0000, 1'b0);

        // contention: data first, then the held fetch
        set_inst(32'hBFC0_0004, 2'd2);
        set_data(1'b0, 32'h8000_1000, 2'd2, 32'd0);
        run_round(0, 0, 0, 0, 0, 32'h1111_2222, 1'b0);
        run_round(0, 1, 0, 0, 0, 32'h3333_4444, 1'b0);

        // three contested rounds, re-requesting whichever port was served
        for (int k = 0; k < 3; k++) begin
            if (!pend_i) set_inst($urandom, 2'd2);
            if (!pend_d) set_data(1'b0, $urandom, 2'd2, 32'd0);
            run_round(0, 0, 0, 0, 0, $urandom, 1'b0);
        end
        drain();

        // byte store, AW two cycles ahead of W
        set_data(1'b1, 32'h8000_0003, 2'd0, 32'h0000_00AA);
        run_round(0, 0, 0, 2, 1, 32'd0, 1'b0);

        // halfword store, W ahead of AW
        set_data(1'b1, 32'h8000_0002, 2'd1, 32'hBEEF_BEEF);
        run_round(0, 0, 2, 0, 0, 32'd0, 1'b0);

        // AR backpressure with the fetch port waiting
        set_inst(32'hBFC0_0100, 2'd2);
        set_data(1'b0, 32'h8000_2000, 2'd1, 32'd0);
        run_round(5, 1, 0, 0, 0, 32'h5A5A_A5A5, 1'b0);
        drain();

        for (int n = 0; n < 40; n++) begin
            add_random_reqs();
            run_round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        drain();

        // reset while waiting in R, then a normal fetch afterwards
        set_inst(32'hBFC0_0200, 2'd2);
        run_round(0, 1, 0, 0, 0, 32'hDEAD_BEEF, 1'b1);
        set_inst(32'hBFC0_0204, 2'd2);
        set_data(1'b0, 32'h8000_3000, 2'd2, 32'd0);
        run_round(1, 0, 0, 0, 0, 32'h0BAD_F00D, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_axi_arbiter.md
# sram_axi_arbiter

Bridges the core's two SRAM-like ports onto one AXI3 master. The inst port is read-only; the data port is read/write. Exactly one transaction is outstanding at a time. It sits between the pipeline (whose stall logic consumes `*_addr_ok`/`*_data_ok`) and the SoC AXI crossbar, arbitrates between fetch and load/store, and sequences AR/R or AW/W/B for the winner.

## Interface
- Parameters: `ID_W`, 4, AXI ID width · `INST_ID`, 0, arid for fetch · `DATA_ID`, 1, ar/awid for data
- `clk` in 1: sole clock
- `rst` in 1: asynchronous, active-high reset
- `inst_req` / `inst_addr` / `inst_size` in 1/32/2: fetch request, byte address, size code (0 = B, 1 = H, 2 = W)
- `inst_addr_ok` / `inst_data_ok` out 1/1: request accepted; read data valid
- `inst_rdata` out 32: fetch data
- `data_req` / `data_wr` / `data_addr` / `data_size` / `data_wdata` in 1/1/32/2/32: data request; `data_wr` = 1 means store
- `data_addr_ok` / `data_data_ok` out 1/1: accepted; load data valid or store completed
- `data_rdata` out 32: load data
- AXI AR: `arid` out ID_W, `araddr` out 32, `arlen` out 4 (= 0), `arsize` out 3, `arburst` out 2 (= 01), `arvalid` out 1, `arready` in 1
- AXI R: `rid` in ID_W, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1
- AXI AW: `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid` out, `awready` in (same encodings as AR)
- AXI W: `wdata` out 32, `wstrb` out 4, `wlast` out 1 (= 1), `wvalid` out 1, `wready` in 1
- AXI B: `bid` in ID_W, `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE: grant selection when one or more reqs are high (see Configuration). Grant cycle:
  - pulse the winner's `addr_ok` combinationally;
  - latch owner, wr, addr, size, wdata;
  - next state is AR (read) or AW_W (write).
- AR: `arvalid` = 1 with latched fields and `arid` = owner ID. Leave on `arready` for R.
- R: `rready` = 1. On `rvalid`, pulse the owner's `data_ok`, drive owner `rdata` = AXI `rdata`, return to IDLE.
  - `rid`, `rresp` and `rlast` are ignored (single outstanding transaction).
- AW_W: `awvalid` and `wvalid` both raised on entry.
  - Each drops independently after its handshake; per-channel done flags track this.
  - Go to B once both are done, whether the handshakes happen together or in either order.
- B: `bready` = 1. On `bvalid`, pulse `data_data_ok`, return to IDLE.
- `wstrb`:
  - size 0 → `4'b0001 << addr[1:0]`
  - size 1 → `4'b0011 << {addr[1],1'b0}`
  - size 2 or 3 → `4'b1111`
- `wdata` is passed unshifted; the core pre-replicates store data.
- `arsize` and `awsize` = `{1'b0,size}`.
- `*_addr_ok` is never asserted outside IDLE. A requester holding `req` high across a busy period is accepted at the next IDLE.
- `rdata` outputs hold their last value when `data_ok` = 0.

## Timing
- Reset (async, immediate): state = IDLE; all `*valid`, `rready`, `bready`, `addr_ok` and `data_ok` = 0; latched fields = 0; round-robin pointer = data.
- Reset mid-transaction abandons it; no `data_ok` is ever issued for it.
- Minimum read: grant cycle T; `arvalid` at T+1; with `arready`@T+1 and `rvalid`@T+2, `data_ok` at T+2 and IDLE at T+3. Next grant no earlier than T+3.
- Minimum write: grant T; AW and W both at T+1; `bvalid`@T+2 gives `data_data_ok` at T+2.
- `data_ok` is combinational from `rvalid`/`bvalid`, gated by state. `addr_ok` is combinational from `req` in IDLE.
- AXI valid signals never drop before their handshake. Address, data and strobe stay stable while valid.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority. Data wins over inst whenever both request in IDLE.
- `ARB_ROUND_ROBIN_EN` defined: a 1-bit pointer selects the preferred port when both request. The pointer flips to the non-granted port after each contested grant. An uncontested grant leaves the pointer unchanged.

## Structure
- Shared package `axi_pkg`:
  - state enum
  - `BURST_INCR` = 2'b01
  - `ID_INST` / `ID_DATA` defaults
  - size codes
- Sub-module `axi_strb_gen`: purely combinational size + addr[1:0] → `wstrb`. Reused later by the uncached store path.

## Test plan
- Inst read only: `inst_req`, addr 0xBFC00000, size 2. Expected: `inst_addr_ok` at T; `araddr` 0xBFC00000, `arid` 0, `arsize` 3'b010 at T+1; `rdata` 0x3C1D0000 gives `inst_data_ok` with that value.
- Contention, macro off: both reqs high in IDLE. Expected: data granted first; inst granted in the first IDLE after `data_data_ok`. Macro on, three contested rounds: grants data, inst, data.
- Byte store: addr 0x80000003, size 0, wdata 0x000000AA. Expected: `wstrb` 4'b1000, `awsize` 0. `awready` two cycles before `wready` still gives a single `data_data_ok` after `bvalid`.
- Halfword store at 0x80000002. Expected: `wstrb` 4'b1100. W handshake before AW is also accepted.
- Backpressure: `arready` held low for 5 cycles. Expected: `arvalid` and `araddr` stable for those cycles; no second `addr_ok`.
- Reset asserted in state R. Expected: all valids low and IDLE immediately. A later `rvalid` produces no `data_ok`.
